// File: rtl/dmem_port_arbiter.sv
// Arbiter that shares one synchronous data memory between the CPU load/store path and a host/debug port.
// Define DMEM_ARB_ANTISTARVE_EN to give the host priority after MAX_WAIT denied cycles; otherwise the CPU always wins.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("dmem_port_arbiter: MAX_WAIT must be in 1..15");
  end

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  owner_e rd_owner_q, rd_owner_d;
  logic   host_prio;

`ifdef DMEM_ARB_ANTISTARVE_EN
  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    host_prio  = host_req && (wait_cnt_q == MaxWait);
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wait_cnt_d = '0;
    if (host_req && !host_gnt) begin
      wait_cnt_d = (wait_cnt_q == MaxWait) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) wait_cnt_q <= '0;
    else      wait_cnt_q <= wait_cnt_d;
  end
`else
  always_comb host_prio = 1'b0;
`endif

  // Grants are gated by reset so nothing reaches the memory while rst is low.
  always_comb begin
    cpu_gnt  = rst && cpu_req && !host_prio;
    host_gnt = rst && host_req && (!cpu_req || host_prio);
  end

  always_comb begin
    mem_en    = cpu_gnt || host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we)        rd_owner_d = OWN_CPU;
    else if (host_gnt && !host_we) rd_owner_d = OWN_HOST;
  end

  always_ff @(posedge clk) begin
    if (!rst) rd_owner_q <= OWN_NONE;
    else      rd_owner_q <= rd_owner_d;
  end

  // A read in flight when reset arrives is dropped immediately, not one cycle later.
  always_comb begin
    cpu_rvalid  = rst && (rd_owner_q == OWN_CPU);
    host_rvalid = rst && (rd_owner_q == OWN_HOST);
    cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
    host_rdata  = host_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a behavioural 512x32 synchronous memory.
// Inputs are driven just after the falling edge and outputs are sampled 1ns later.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [8:0]  cpu_addr, host_addr;
  logic [31:0] cpu_wdata, host_wdata;
  logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
  logic [31:0] cpu_rdata, host_rdata;
  logic        mem_en, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [0:511];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  dmem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic host_write(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    idle();
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    #1;
    total++;
    if (host_gnt !== 1'b1) begin bad++; $display("FAIL preload_gnt addr=%h: got=%b exp=1", a, host_gnt); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005; cpu_wdata = 32'h1234_5678;
    host_req = 1'b1; host_we = 1'b1; host_addr = 9'h1ff; host_wdata = 32'hffff_ffff;
    @(negedge clk);
    #1;
    total++;
    if ({cpu_gnt, host_gnt, mem_en, mem_we, cpu_rvalid, host_rvalid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got gnt=%b%b en=%b we=%b rv=%b%b exp all 0",
               cpu_gnt, host_gnt, mem_en, mem_we, cpu_rvalid, host_rvalid);
    end
    total++;
    if (mem_addr !== 9'h0) begin bad++; $display("FAIL reset_addr: got=%h exp=000", mem_addr); end
    total++;
    if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got=%h exp=0", mem_wdata); end
    total++;
    if ({cpu_rdata, host_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata: got cpu=%h host=%h exp 0", cpu_rdata, host_rdata);
    end
    @(negedge clk);
    idle();
    rst = 1'b1;
  endtask

  task automatic test_single_cpu_read();
    host_write(9'h010, 32'hDEAD_BEEF);
    @(negedge clk);
    idle();
    cpu_req = 1'b1; cpu_addr = 9'h010;
    #1;
    total++;
    if ({cpu_gnt, host_gnt, mem_en, mem_we} !== 4'b1010) begin
      bad++; $display("FAIL cpu_rd_grant: got gnt=%b%b en=%b we=%b exp 1010", cpu_gnt, host_gnt, mem_en, mem_we);
    end
    total++;
    if (mem_addr !== 9'h010) begin bad++; $display("FAIL cpu_rd_addr: got=%h exp=010", mem_addr); end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL cpu_rd_data: got rv=%b d=%h exp rv=1 d=deadbeef", cpu_rvalid, cpu_rdata);
    end
    total++;
    if (host_rvalid !== 1'b0 || host_rdata !== 32'h0) begin
      bad++; $display("FAIL cpu_rd_host_quiet: got rv=%b d=%h exp 0", host_rvalid, host_rdata);
    end
    @(negedge clk);
    #1;
    total++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
      bad++; $display("FAIL cpu_rd_one_cycle: got rv=%b d=%h exp 0", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    idle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h020; cpu_wdata = 32'h0000_0005;
    host_req = 1'b1; host_we = 1'b0; host_addr = 9'h020;
    #1;
    total++;
    if ({cpu_gnt, host_gnt} !== 2'b10) begin bad++; $display("FAIL sim_first_gnt: got=%b%b exp=10", cpu_gnt, host_gnt); end
    total++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'h5 || mem_addr !== 9'h020) begin
      bad++; $display("FAIL sim_first_mux: got we=%b a=%h d=%h exp 1/020/5", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
    #1;
    total++;
    if ({cpu_gnt, host_gnt} !== 2'b01) begin bad++; $display("FAIL sim_second_gnt: got=%b%b exp=01", cpu_gnt, host_gnt); end
    total++;
    if (mem_we !== 1'b0 || mem_addr !== 9'h020) begin
      bad++; $display("FAIL sim_second_mux: got we=%b a=%h exp 0/020", mem_we, mem_addr);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (host_rvalid !== 1'b1 || host_rdata !== 32'h5 || cpu_rvalid !== 1'b0) begin
      bad++; $display("FAIL sim_host_data: got hrv=%b hd=%h crv=%b exp 1/5/0", host_rvalid, host_rdata, cpu_rvalid);
    end
  endtask

  task automatic test_read_before_write();
    host_write(9'h030, 32'h1111_2222);
    @(negedge clk);
    idle();
    cpu_req = 1'b1; cpu_addr = 9'h030;
    @(negedge clk);
    cpu_we = 1'b1; cpu_wdata = 32'h3333_4444;
    #1;
    total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1111_2222) begin
      bad++; $display("FAIL rbw_old_data: got rv=%b d=%h exp 1/11112222", cpu_rvalid, cpu_rdata);
    end
    @(negedge clk);
    cpu_we = 1'b0; cpu_wdata = '0;
    #1;
    total++;
    if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL rbw_write_no_resp: got rv=%b exp 0", cpu_rvalid); end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h3333_4444) begin
      bad++; $display("FAIL rbw_new_data: got rv=%b d=%h exp 1/33334444", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_starvation();
    logic exp_h;
`ifdef DMEM_ARB_ANTISTARVE_EN
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h040; cpu_wdata = 32'(c);
      host_req = 1'b1; host_we = 1'b0; host_addr = 9'h041;
      #1;
      exp_h = ((c % 5) == 4);
      total++;
      if ({cpu_gnt, host_gnt} !== {!exp_h, exp_h}) begin
        bad++; $display("FAIL starve_gnt c=%0d: got=%b%b exp=%b%b", c, cpu_gnt, host_gnt, !exp_h, exp_h);
      end
      total++;
      if (mem_addr !== (exp_h ? 9'h041 : 9'h040)) begin
        bad++; $display("FAIL starve_addr c=%0d: got=%h exp=%h", c, mem_addr, exp_h ? 9'h041 : 9'h040);
      end
    end
`else
    exp_h = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h040; cpu_wdata = 32'(c);
      host_req = 1'b1; host_we = 1'b0; host_addr = 9'h041;
      #1;
      total++;
      if ({cpu_gnt, host_gnt} !== {!exp_h, exp_h}) begin
        bad++; $display("FAIL strict_gnt c=%0d: got=%b%b exp=10", c, cpu_gnt, host_gnt);
      end
    end
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    total++;
    if ({cpu_gnt, host_gnt} !== 2'b01) begin bad++; $display("FAIL strict_release: got=%b%b exp=01", cpu_gnt, host_gnt); end
`endif
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_mid_read();
    host_write(9'h050, 32'hCAFE_F00D);
    @(negedge clk);
    idle();
    host_req = 1'b1; host_addr = 9'h050;
    #1;
    total++;
    if (host_gnt !== 1'b1) begin bad++; $display("FAIL rmr_grant: got=%b exp=1", host_gnt); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst = 1'b0;
      cpu_req = 1'b1; cpu_addr = 9'h051;
      #1;
      total++;
      if ({host_rvalid, cpu_rvalid, mem_en, cpu_gnt, host_gnt} !== 5'b0) begin
        bad++; $display("FAIL rmr_in_reset k=%0d: got hrv=%b crv=%b en=%b gnt=%b%b exp 0",
                        k, host_rvalid, cpu_rvalid, mem_en, cpu_gnt, host_gnt);
      end
      total++;
      if (host_rdata !== 32'h0) begin bad++; $display("FAIL rmr_rdata k=%0d: got=%h exp=0", k, host_rdata); end
    end
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    total++;
    if (host_rvalid !== 1'b0) begin bad++; $display("FAIL rmr_after: got hrv=%b exp 0", host_rvalid); end
`ifdef DMEM_ARB_ANTISTARVE_EN
    // Build up a partial wait count, reset, and confirm the host waits the full window again.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      rst = (k != 3);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h060; cpu_wdata = 32'(k);
      host_req = 1'b1; host_we = 1'b0; host_addr = 9'h061;
      #1;
      total++;
      if (host_gnt !== (k == 8)) begin bad++; $display("FAIL rmr_wait_clear k=%0d: got=%b exp=%b", k, host_gnt, k == 8); end
    end
`endif
    @(negedge clk);
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d;
    for (int i = 0; i < 8; i++) host_write(9'(i), 32'hB0B0_0000 | 32'(i * 32'h111));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle();
      if (i < 8) begin cpu_req = 1'b1; cpu_addr = 9'(i); end
      #1;
      if (i < 8) begin
        total++;
        if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt i=%0d: got=%b exp=1", i, cpu_gnt); end
      end
      if (i >= 1 && i <= 8) begin
        exp_d = 32'hB0B0_0000 | 32'((i - 1) * 32'h111);
        total++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp_d) begin
          bad++; $display("FAIL b2b_data i=%0d: got rv=%b d=%h exp rv=1 d=%h", i, cpu_rvalid, cpu_rdata, exp_d);
        end
      end else if (i == 9) begin
        total++;
        if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_end: got rv=%b exp 0", cpu_rvalid); end
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_single_cpu_read();
    test_simultaneous();
    test_read_before_write();
    test_starvation();
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-port arbiter that shares the single 512x32 data memory between the processor's load/store path and a host/debug port used for loading test vectors and dumping results. It grants at most one access per cycle, routes the granted request to the memory, and returns synchronous read data to the requester that issued it. It sits between the processor core, the host port and the data memory array.

## Interface
- ADDR_W, 9, memory address width (512 words)
- DATA_W, 32, data word width
- MAX_WAIT, 4, consecutive denied host cycles before host gets priority (range 1..15)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- cpu_req  in  1  processor access request
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  processor word address
- cpu_wdata  in  DATA_W  processor store data
- cpu_gnt  out  1  processor request accepted this cycle
- cpu_rvalid  out  1  processor load data valid
- cpu_rdata  out  DATA_W  processor load data
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host request, same meaning as cpu_*
- host_gnt  out  1  host request accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe

## Operation
- Handshake: a requester holds req, we, addr and wdata stable until it sees gnt high. A transfer occurs in a cycle where gnt is 1. The requester may drop req or present a new request in the following cycle.
- Grant is combinational from the current requests and the registered state. cpu_gnt and host_gnt are never both 1.
- Mux: mem_en = cpu_gnt | host_gnt. mem_we, mem_addr and mem_wdata come from the granted requester. When nothing is granted, all mem_* outputs are 0.
- Priority: CPU wins by default. Host wins when host_req = 1 and wait_cnt == MAX_WAIT (anti-starvation, see Configuration).
- wait_cnt (4 bits):
  - Increments when host_req = 1 and host_gnt = 0, saturating at MAX_WAIT.
  - Clears when host_gnt = 1 or host_req = 0.
- Read owner register rd_owner ∈ {NONE, CPU, HOST}:
  - Set on each clock edge to the owner of a granted read (mem_en & !mem_we).
  - Set to NONE otherwise, including for granted writes.
- Read return:
  - cpu_rvalid = (rd_owner == CPU). cpu_rdata = mem_rdata when cpu_rvalid = 1, else 0.
  - Host side behaves identically with HOST.
- Writes produce no response. They commit at the clock edge ending the grant cycle.
- Back-to-back grants are allowed every cycle to either port. A read followed by a write to the same address returns the old data.
- While rst = 0:
  - All gnt and mem_* outputs are 0.
  - At the next edge, rd_owner becomes NONE and wait_cnt becomes 0. This holds even if reset is asserted mid-read: the pending rvalid is dropped.

## Timing
- Grant latency: 0 cycles (same cycle as req when the requester wins arbitration).
- Read latency: rvalid and rdata appear exactly 1 cycle after the grant cycle, for 1 cycle.
- Worst-case host wait with anti-starvation: MAX_WAIT denied cycles, then a grant in the next requested cycle.
- Reset values after the first edge with rst = 0: cpu_gnt = host_gnt = 0, cpu_rvalid = host_rvalid = 0, cpu_rdata = host_rdata = 0, mem_en = mem_we = 0, mem_addr = 0, mem_wdata = 0.
- No combinational path from mem_rdata to any gnt or mem_* output.

## Configuration
- DMEM_ARB_ANTISTARVE_EN defined: the wait_cnt counter and the host-priority override are as described above.
- Not defined:
  - wait_cnt is not implemented.
  - Arbitration is strict fixed priority: host_gnt = host_req & !cpu_req.
  - A continuously requesting CPU can starve the host indefinitely.
- All other behaviour is identical in both builds.

## Test plan
- Single CPU read: mem preloaded with 0xDEADBEEF at address 9'h010, cpu_req = 1, cpu_we = 0, cpu_addr = 9'h010 for 1 cycle. Required: cpu_gnt = 1 in the same cycle; next cycle cpu_rvalid = 1 and cpu_rdata = 0xDEADBEEF; host_rvalid = 0 throughout.
- Simultaneous requests: CPU writes 0x00000005 to 9'h020 while host reads 9'h020 in the same cycle. Required: cpu_gnt = 1 and host_gnt = 0 in the first cycle. Host is granted in the following cycle and receives host_rdata = 0x00000005 one cycle later.
- Anti-starvation (macro on, MAX_WAIT = 4): cpu_req held at 1 continuously, host_req = 1 from cycle 0. Required: host_gnt = 0 for cycles 0–3 and host_gnt = 1 at cycle 4 with cpu_gnt = 0. cpu_gnt returns to 1 at cycle 5, and the pattern repeats every 5 cycles.
- Same stimulus with macro off: host_gnt stays 0 for 50 cycles. host_gnt = 1 occurs in the first cycle after cpu_req drops.
- Reset mid-read: host read granted at cycle N, rst = 0 sampled at edge N+1. Required: host_rvalid = 0 at N+1, wait_cnt = 0 afterwards, and no mem_en while rst = 0.
- Back-to-back stream: CPU reads addresses 0..7 on consecutive cycles. Required: 8 consecutive cycles of cpu_rvalid = 1 with data matching the preloaded words in order, and no gaps.
